// File: rtl/mm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_sequencer_pkg
// Description : Shared state encoding and default dimensions for the
//               matrix-multiply sequencer and its index counters.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_sequencer_pkg;

    // Default operand dimension and the matching index width
    localparam int C_N_DEFAULT  = 3;
    localparam int C_IW_DEFAULT = 2;

    // Sequencer states; unused encodings recover to ST_IDLE
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : mm_sequencer_pkg
`default_nettype wire

// File: rtl/mm_index_counter.sv
`default_nettype none
// ============================================================================
// Module      : mm_index_counter
// Description : Mod-N up counter with enable, synchronous clear, active-low
//               synchronous reset and a terminal-count flag (count == N-1).
// Revision    : 1.0 - initial release
// ============================================================================
module mm_index_counter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [IW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [IW-1:0] C_LAST = IW'(N - 1);

    logic [IW-1:0] cnt_q;
    logic [IW-1:0] cnt_d;

    // Next count: clear beats enable, enable wraps N-1 back to 0
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!mr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == C_LAST);

endmodule : mm_index_counter
`default_nettype wire

// File: rtl/mm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mm_sequencer
// Description : Control sequencer for an N x N matrix multiply on a single
//               MAC. For each output element (i,j) it clears the accumulator,
//               accumulates N products (k = 0..N-1) and writes the result.
//               Supports stall (hold) and cancel (abort).
// Revision    : 1.0 - initial release
// ============================================================================
module mm_sequencer
    import mm_sequencer_pkg::*;
#(
    parameter int N  = C_N_DEFAULT,
    parameter int IW = C_IW_DEFAULT
) (
    input  logic          clk,
    input  logic          mr,
    input  logic          start,
    input  logic          hold,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          clr_acc,
    output logic          mac_en,
    output logic          c_we,
    output logic [IW-1:0] row_i,
    output logic [IW-1:0] col_j,
    output logic [IW-1:0] dot_k
);

    state_t state_q;
    state_t state_d;

    logic w_abort;
    logic w_adv;
    logic w_clr_all;
    logic w_last_elem;
    logic w_k_clr;
    logic w_k_en;
    logic w_j_en;
    logic w_i_en;
    logic w_i_tc;
    logic w_j_tc;
    logic w_k_tc;

    // Abort only matters once a job has left IDLE; it overrides hold
    assign w_abort     = abort && (state_q != ST_IDLE);
    // The machine advances only in cycles that are neither held nor aborted
    assign w_adv       = !hold && !w_abort;
    assign w_last_elem = w_i_tc && w_j_tc;

    // All indices return to zero on abort, on job acceptance and on job exit
    assign w_clr_all = w_abort
                    || (w_adv && (state_q == ST_IDLE) && start)
                    || (w_adv && (state_q == ST_DONE));

    // k restarts for every element; it stays at N-1 through WRITE
    assign w_k_clr = w_clr_all || (w_adv && (state_q == ST_CLEAR));
    assign w_k_en  = w_adv && (state_q == ST_ACCUM) && !w_k_tc;
    // j steps after each write except the last; its wrap carries into i
    assign w_j_en  = w_adv && (state_q == ST_WRITE) && !w_last_elem;
    assign w_i_en  = w_j_en && w_j_tc;

    mm_index_counter #(.N(N), .IW(IW)) u_cnt_i (
        .clk   (clk),
        .mr    (mr),
        .clr_i (w_clr_all),
        .en_i  (w_i_en),
        .cnt_o (row_i),
        .tc_o  (w_i_tc)
    );

    mm_index_counter #(.N(N), .IW(IW)) u_cnt_j (
        .clk   (clk),
        .mr    (mr),
        .clr_i (w_clr_all),
        .en_i  (w_j_en),
        .cnt_o (col_j),
        .tc_o  (w_j_tc)
    );

    mm_index_counter #(.N(N), .IW(IW)) u_cnt_k (
        .clk   (clk),
        .mr    (mr),
        .clr_i (w_k_clr),
        .en_i  (w_k_en),
        .cnt_o (dot_k),
        .tc_o  (w_k_tc)
    );

    // State register with synchronous active-low master reset
    always_ff @(posedge clk) begin
        if (!mr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: abort > hold > normal sequencing
    always_comb begin
        state_d = state_q;
        if (w_abort) begin
            state_d = ST_IDLE;
        end else if (!hold) begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_CLEAR;
                ST_CLEAR: state_d = ST_ACCUM;
                ST_ACCUM: if (w_k_tc) state_d = ST_WRITE;
                ST_WRITE: state_d = w_last_elem ? ST_DONE : ST_CLEAR;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Moore output decode; hold suppresses strobes but not busy
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        clr_acc = 1'b0;
        mac_en  = 1'b0;
        c_we    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy    = 1'b1;
                clr_acc = !hold;
            end
            ST_ACCUM: begin
                busy   = 1'b1;
                mac_en = !hold;
            end
            ST_WRITE: begin
                busy = 1'b1;
                c_we = !hold;
            end
            ST_DONE: begin
                done = !hold;
            end
            default: ;
        endcase
    end

endmodule : mm_sequencer
`default_nettype wire

// File: tb/tb_mm_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mm_sequencer
// Description : Directed self-checking bench for mm_sequencer (N=3 and N=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=3 instance
    logic       mr, start, hold, abort;
    logic       busy, done, clr_acc, mac_en, c_we;
    logic [1:0] row_i, col_j, dot_k;
    // N=2 instance
    logic       mr2, start2, hold2, abort2;
    logic       busy2, done2, clr_acc2, mac_en2, c_we2;
    logic [0:0] row2, col2, dot2;

    int total = 0;
    int bad   = 0;

    mm_sequencer #(.N(3), .IW(2)) dut (
        .clk(clk), .mr(mr), .start(start), .hold(hold), .abort(abort),
        .busy(busy), .done(done), .clr_acc(clr_acc), .mac_en(mac_en),
        .c_we(c_we), .row_i(row_i), .col_j(col_j), .dot_k(dot_k)
    );

    mm_sequencer #(.N(2), .IW(1)) dut2 (
        .clk(clk), .mr(mr2), .start(start2), .hold(hold2), .abort(abort2),
        .busy(busy2), .done(done2), .clr_acc(clr_acc2), .mac_en(mac_en2),
        .c_we(c_we2), .row_i(row2), .col_j(col2), .dot_k(dot2)
    );

    // Inputs change 1ns after a rising edge; outputs are sampled at the falling edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        mr = 1'b0; start = 1'b1; hold = 1'b0; abort = 1'b0;
        mr2 = 1'b0; start2 = 1'b1; hold2 = 1'b0; abort2 = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        obs = {busy, done, clr_acc, mac_en, c_we};
        total++;
        if (obs !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", obs);
        end
        total++;
        if ({row_i, col_j, dot_k} !== 6'b0) begin
            bad++; $display("FAIL reset_idx got=%b want=000000", {row_i, col_j, dot_k});
        end
        total++;
        if ({busy2, done2, clr_acc2, mac_en2, c_we2} !== 5'b0) begin
            bad++; $display("FAIL reset_flags_n2 got=%b want=00000",
                            {busy2, done2, clr_acc2, mac_en2, c_we2});
        end
        start = 1'b0; start2 = 1'b0;
        next_cycle();
        mr = 1'b1; mr2 = 1'b1;
        next_cycle();
    endtask

    // Full N=3 job: per element CLEAR, ACCUM x3, WRITE; done at cycle 46
    task automatic test_basic();
        logic [4:0] obs, exp_f;
        int e, ph, cwe;
        cwe = 0;
        start = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL basic_c0_busy got=%b want=0", busy);
        end
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            e = 0; ph = 0;
            if (c <= 45) begin
                e  = (c - 1) / 5;
                ph = (c - 1) % 5;
                exp_f = (ph == 0) ? 5'b10100 : (ph == 4) ? 5'b10001 : 5'b10010;
            end else if (c == 46) begin
                exp_f = 5'b01000;
            end else begin
                exp_f = 5'b00000;
            end
            obs = {busy, done, clr_acc, mac_en, c_we};
            if (c_we) cwe++;
            total++;
            if (obs !== exp_f) begin
                bad++; $display("FAIL basic_flags cyc=%0d got=%b want=%b", c, obs, exp_f);
            end
            if (c <= 45 && ph >= 1) begin
                total++;
                if ({row_i, col_j} !== {2'(e / 3), 2'(e % 3)}
                    || (ph <= 3 && dot_k !== 2'(ph - 1))) begin
                    bad++; $display("FAIL basic_idx cyc=%0d got i=%0d j=%0d k=%0d want i=%0d j=%0d k=%0d",
                                    c, row_i, col_j, dot_k, e / 3, e % 3, (ph <= 3) ? ph - 1 : 2);
                end
            end
            if (c == 47) begin
                total++;
                if ({row_i, col_j, dot_k} !== 6'b0) begin
                    bad++; $display("FAIL basic_idle_idx got=%b want=000000", {row_i, col_j, dot_k});
                end
            end
            next_cycle();
        end
        total++;
        if (cwe != 9) begin
            bad++; $display("FAIL basic_cwe_count got=%0d want=9", cwe);
        end
    endtask

    // Hold for 3 cycles while ACCUM k=1 of element (0,0); done slips to 49
    task automatic test_hold();
        logic [4:0] obs, exp_f;
        int ce, e, ph, mac0, mac_all, done_at;
        mac0 = 0; mac_all = 0; done_at = -1;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            hold = (c >= 3 && c <= 5);
            @(negedge clk);
            ce = (c < 3) ? c : c - 3;
            if (hold) begin
                exp_f = 5'b10000;
            end else if (ce <= 45) begin
                ph = (ce - 1) % 5;
                exp_f = (ph == 0) ? 5'b10100 : (ph == 4) ? 5'b10001 : 5'b10010;
            end else if (ce == 46) begin
                exp_f = 5'b01000;
            end else begin
                exp_f = 5'b00000;
            end
            obs = {busy, done, clr_acc, mac_en, c_we};
            total++;
            if (obs !== exp_f) begin
                bad++; $display("FAIL hold_flags cyc=%0d got=%b want=%b", c, obs, exp_f);
            end
            if (hold) begin
                total++;
                if (dot_k !== 2'd1) begin
                    bad++; $display("FAIL hold_k cyc=%0d got=%0d want=1", c, dot_k);
                end
            end
            e = (ce - 1) / 5;
            if (mac_en) begin
                mac_all++;
                if (e == 0 && c <= 8) mac0++;
            end
            if (done) done_at = c;
            next_cycle();
        end
        hold = 1'b0;
        total++;
        if (mac0 != 3 || mac_all != 27) begin
            bad++; $display("FAIL hold_mac_count got=%0d/%0d want=3/27", mac0, mac_all);
        end
        total++;
        if (done_at != 49) begin
            bad++; $display("FAIL hold_done_cycle got=%0d want=49", done_at);
        end
    endtask

    // Abort in the last ACCUM of element (1,0) so its WRITE never happens
    task automatic test_abort();
        logic [4:0] obs;
        int cwe, dn;
        cwe = 0; dn = 0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c_we) cwe++;
            next_cycle();
        end
        abort = 1'b1;
        @(negedge clk);
        total++;
        if ({mac_en, row_i, col_j, dot_k} !== {1'b1, 2'd1, 2'd0, 2'd2}) begin
            bad++; $display("FAIL abort_pre got mac=%b i=%0d j=%0d k=%0d want mac=1 i=1 j=0 k=2",
                            mac_en, row_i, col_j, dot_k);
        end
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        obs = {busy, done, clr_acc, mac_en, c_we};
        total++;
        if (obs !== 5'b0 || {row_i, col_j, dot_k} !== 6'b0) begin
            bad++; $display("FAIL abort_after got flags=%b idx=%b want 00000/000000",
                            obs, {row_i, col_j, dot_k});
        end
        total++;
        if (cwe != 3) begin
            bad++; $display("FAIL abort_cwe_before got=%0d want=3", cwe);
        end
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done || c_we || busy) dn++;
            next_cycle();
        end
        total++;
        if (dn != 0) begin
            bad++; $display("FAIL abort_no_activity got=%0d want=0", dn);
        end
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        total++;
        if ({clr_acc, row_i, col_j} !== {1'b1, 4'b0}) begin
            bad++; $display("FAIL abort_restart_clear got clr=%b i=%0d j=%0d want clr=1 i=0 j=0",
                            clr_acc, row_i, col_j);
        end
        for (int c = 1; c <= 4; c++) next_cycle();
        @(negedge clk);
        total++;
        if ({c_we, row_i, col_j} !== {1'b1, 4'b0}) begin
            bad++; $display("FAIL abort_restart_write got we=%b i=%0d j=%0d want we=1 i=0 j=0",
                            c_we, row_i, col_j);
        end
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        next_cycle();
    endtask

    // Master reset in the middle of ACCUM, with start held across release
    task automatic test_reset_mid();
        logic [4:0] obs;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        mr = 1'b0; start = 1'b1;
        next_cycle();
        @(negedge clk);
        obs = {busy, done, clr_acc, mac_en, c_we};
        total++;
        if (obs !== 5'b0 || {row_i, col_j, dot_k} !== 6'b0) begin
            bad++; $display("FAIL mrmid_after got flags=%b idx=%b want 00000/000000",
                            obs, {row_i, col_j, dot_k});
        end
        next_cycle();
        mr = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL mrmid_start_discarded got busy=%b want=0", busy);
        end
        next_cycle();
        @(negedge clk);
        obs = {busy, done, clr_acc, mac_en, c_we};
        total++;
        if (obs !== 5'b10100) begin
            bad++; $display("FAIL mrmid_accept got=%b want=10100", obs);
        end
        start = 1'b0;
        abort = 1'b1;
        next_cycle();
        abort = 1'b0;
        next_cycle();
    endtask

    // Start pulses while busy and in DONE must not create a second job
    task automatic test_ignore_start();
        int dn, clr, done_at;
        dn = 0; clr = 0; done_at = -1;
        start = 1'b1;
        next_cycle();
        for (int c = 1; c <= 55; c++) begin
            start = (c == 10 || c == 46);
            @(negedge clk);
            if (done) begin dn++; done_at = c; end
            if (clr_acc) clr++;
            next_cycle();
        end
        start = 1'b0;
        total++;
        if (dn != 1 || done_at != 46) begin
            bad++; $display("FAIL ignore_done got count=%0d at=%0d want count=1 at=46", dn, done_at);
        end
        total++;
        if (clr != 9) begin
            bad++; $display("FAIL ignore_jobs got clr=%0d want=9", clr);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL ignore_idle got busy=%b want=0", busy);
        end
        next_cycle();
    endtask

    // N=2 build: 16 busy cycles, 4 writes, done at t+17; abort beats hold
    task automatic test_n2();
        int nb, nw, done_at;
        logic [4:0] obs;
        nb = 0; nw = 0; done_at = -1;
        start2 = 1'b1;
        next_cycle();
        start2 = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if (busy2) nb++;
            if (c_we2) nw++;
            if (done2) done_at = c;
            next_cycle();
        end
        total++;
        if (nb != 16 || nw != 4) begin
            bad++; $display("FAIL n2_counts got busy=%0d we=%0d want busy=16 we=4", nb, nw);
        end
        total++;
        if (done_at != 17) begin
            bad++; $display("FAIL n2_done_cycle got=%0d want=17", done_at);
        end
        start2 = 1'b1;
        next_cycle();
        start2 = 1'b0;
        next_cycle();
        hold2 = 1'b1; abort2 = 1'b1;
        @(negedge clk);
        total++;
        if ({busy2, mac_en2} !== 2'b10) begin
            bad++; $display("FAIL n2_held got busy=%b mac=%b want busy=1 mac=0", busy2, mac_en2);
        end
        next_cycle();
        hold2 = 1'b0; abort2 = 1'b0;
        @(negedge clk);
        obs = {busy2, done2, clr_acc2, mac_en2, c_we2};
        total++;
        if (obs !== 5'b0 || {row2, col2, dot2} !== 3'b0) begin
            bad++; $display("FAIL n2_abort_wins got flags=%b idx=%b want 00000/000",
                            obs, {row2, col2, dot2});
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_abort();
        test_reset_mid();
        test_ignore_start();
        test_n2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_mm_sequencer
`default_nettype wire
